// File: rtl/bcd_display_ctrl_if.sv
// Load/result handshake and display pins of the BCD seven-segment controller.
// The driver side uses master; the controller uses slave.
interface bcd_display_ctrl_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 4
);
  logic [WIDTH-1:0]    value;
  logic                valid;
  logic                blank_lz;
  logic [7:0]          pwm_in;
  logic                busy;
  logic                overflow;
  logic [4*DIGITS-1:0] bcd_out;
  logic [DIGITS-1:0]   SegmentDrivers;
  logic [7:0]          SevenSegment;

  modport master (
    output value, valid, blank_lz, pwm_in,
    input  busy, overflow, bcd_out, SegmentDrivers, SevenSegment
  );

  modport slave (
    input  value, valid, blank_lz, pwm_in,
    output busy, overflow, bcd_out, SegmentDrivers, SevenSegment
  );
endinterface

// File: rtl/bcd_display_ctrl.sv
// Sequential double-dabble binary-to-BCD converter with a one-deep pending load,
// plus a multiplexed, PWM-dimmed seven-segment display of the committed result.
module bcd_display_ctrl #(
  parameter int WIDTH       = 16,
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic               CLK100MHZ,
  input  logic               reset,
  bcd_display_ctrl_if.slave  bus
);

  // Decimal digits needed for 2^WIDTH-1: floor(WIDTH*log10(2)) + 1.
  localparam int SCR_MIN = (WIDTH * 30103) / 100000 + 1;
  localparam int SCR_D   = (SCR_MIN > DIGITS) ? SCR_MIN : DIGITS;
  localparam int SW      = 4 * SCR_D;
  localparam int CW      = $clog2(WIDTH + 1);
  localparam int RW      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CW-1:0] LAST_STEP    = CW'(WIDTH - 1);
  localparam logic [RW-1:0] LAST_REFRESH = RW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] LAST_DIGIT   = IW'(DIGITS - 1);
  localparam logic [7:0]    SEG_BLANK    = 8'hFF;
  localparam logic [7:0]    SEG_DASH     = 8'hBF;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    return 8'hC0;
      4'd1:    return 8'hF9;
      4'd2:    return 8'hA4;
      4'd3:    return 8'hB0;
      4'd4:    return 8'h99;
      4'd5:    return 8'h92;
      4'd6:    return 8'h82;
      4'd7:    return 8'hF8;
      4'd8:    return 8'h80;
      4'd9:    return 8'h90;
      default: return SEG_BLANK;
    endcase
  endfunction

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    bin_q, bin_d;
  logic [SW-1:0]       scr_q, scr_d, scr_adj;
  logic [CW-1:0]       step_q, step_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic                ovf_q, ovf_d, hi_nz;
  logic                pend_vld_q, pend_vld_d;
  logic [WIDTH-1:0]    pend_val_q, pend_val_d;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no path infers a latch.
    scr_adj = scr_q;
    for (int i = 0; i < SCR_D; i++) begin
      if (scr_q[4*i +: 4] > 4'd4) scr_adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
    end
    hi_nz = 1'b0;
    for (int i = DIGITS; i < SCR_D; i++) hi_nz = hi_nz | (|scr_q[4*i +: 4]);
  end

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    scr_d      = scr_q;
    step_d     = step_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    pend_vld_d = pend_vld_q;
    pend_val_d = pend_val_q;

    // A load while converting (COMMIT included) parks here; a newer one overwrites it.
    if (state_q != IDLE && bus.valid) begin
      pend_vld_d = 1'b1;
      pend_val_d = bus.value;
    end

    case (state_q)
      IDLE: begin
        if (bus.valid) begin
          state_d = SHIFT;
          bin_d   = bus.value;
          scr_d   = '0;
          step_d  = '0;
        end
      end
      SHIFT: begin
        bin_d  = bin_q << 1;
        scr_d  = {scr_adj[SW-2:0], bin_q[WIDTH-1]};
        step_d = step_q + 1'b1;
        if (step_q == LAST_STEP) state_d = COMMIT;
      end
      COMMIT: begin
        bcd_d = scr_q[4*DIGITS-1:0];
        ovf_d = hi_nz;
        if (bus.valid || pend_vld_q) begin
          state_d    = SHIFT;
          bin_d      = bus.valid ? bus.value : pend_val_q;
          scr_d      = '0;
          step_d     = '0;
          pend_vld_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      scr_q      <= '0;
      step_q     <= '0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      pend_vld_q <= 1'b0;
      pend_val_q <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values regardless of order.
      state_q    <= state_d;
      bin_q      <= bin_d;
      scr_q      <= scr_d;
      step_q     <= step_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
      pend_vld_q <= pend_vld_d;
      pend_val_q <= pend_val_d;
    end
  end

  logic [RW-1:0]     refresh_q, refresh_d;
  logic [IW-1:0]     idx_q, idx_d, msnz;
  logic [7:0]        pwm_q, pwm_d, seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [3:0]        digit;

  always_comb begin
    refresh_d = refresh_q + 1'b1;
    idx_d     = idx_q;
    if (refresh_q == LAST_REFRESH) begin
      refresh_d = '0;
      idx_d     = (idx_q == LAST_DIGIT) ? '0 : idx_q + 1'b1;
    end
    pwm_d = pwm_q + 1'b1;

    msnz = '0;
    for (int i = 1; i < DIGITS; i++) begin
      if (|bcd_q[4*i +: 4]) msnz = IW'(i);
    end

    // Display reads only the committed result, never the scratch register.
    digit = bcd_q[4*idx_q +: 4];
    if (ovf_q)                         seg_d = SEG_DASH;
    else if (bus.blank_lz && idx_q > msnz) seg_d = SEG_BLANK;
    else                               seg_d = seg_code(digit);

    an_d = '1;
    if (pwm_q < bus.pwm_in) an_d[idx_q] = 1'b0;
  end

  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      refresh_q <= '0;
      idx_q     <= '0;
      pwm_q     <= '0;
      seg_q     <= SEG_BLANK;
      an_q      <= '1;
    end else begin
      refresh_q <= refresh_d;
      idx_q     <= idx_d;
      pwm_q     <= pwm_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
    end
  end

  assign bus.busy           = (state_q != IDLE);
  assign bus.overflow       = ovf_q;
  assign bus.bcd_out        = bcd_q;
  assign bus.SegmentDrivers = an_q;
  assign bus.SevenSegment   = seg_q;

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Directed bench for bcd_display_ctrl: a 5-digit instance for conversion, display,
// PWM and reset behaviour, and a 4-digit instance for the overflow case.
module tb_bcd_display_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  bcd_display_ctrl_if #(.WIDTH(16), .DIGITS(5)) bus5 ();
  bcd_display_ctrl_if #(.WIDTH(16), .DIGITS(4)) bus4 ();

  bcd_display_ctrl #(.WIDTH(16), .DIGITS(5), .REFRESH_DIV(4)) u_dut5 (
    .CLK100MHZ (clk),
    .reset     (rst_n),
    .bus       (bus5)
  );

  bcd_display_ctrl #(.WIDTH(16), .DIGITS(4), .REFRESH_DIV(4)) u_dut4 (
    .CLK100MHZ (clk),
    .reset     (rst_n),
    .bus       (bus4)
  );

  typedef struct {
    logic [15:0] value;
    logic        blank;
    logic [19:0] bcd;
    logic [39:0] segs;   // digit i code in bits [8*i +: 8]
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic dut_busy(input bit w);
    return w ? bus4.busy : bus5.busy;
  endfunction

  function automatic logic [19:0] dut_bcd(input bit w);
    return w ? {4'h0, bus4.bcd_out} : bus5.bcd_out;
  endfunction

  function automatic logic dut_ovf(input bit w);
    return w ? bus4.overflow : bus5.overflow;
  endfunction

  function automatic logic [4:0] dut_an(input bit w);
    return w ? {1'b1, bus4.SegmentDrivers} : bus5.SegmentDrivers;
  endfunction

  function automatic logic [7:0] dut_seg(input bit w);
    return w ? bus4.SevenSegment : bus5.SevenSegment;
  endfunction

  // Pulse valid for one edge, then count samples with busy=1 (bounded).
  task automatic convert(input bit w, input logic [15:0] v, output int nbusy,
                         output logic [19:0] last_busy_bcd);
    if (w) begin bus4.value = v; bus4.valid = 1'b1; end
    else   begin bus5.value = v; bus5.valid = 1'b1; end
    step();
    bus4.valid = 1'b0;
    bus5.valid = 1'b0;
    nbusy = 0;
    last_busy_bcd = 'x;
    for (int g = 0; g < 64 && dut_busy(w); g++) begin
      nbusy++;
      last_busy_bcd = dut_bcd(w);
      step();
    end
  endtask

  // Watch the pins for a while; for each digit record the code seen while its anode was low.
  task automatic check_digits(input string name, input bit w, input logic [39:0] exp);
    logic [7:0] obs [5];
    bit         seen [5];
    logic [4:0] an;
    logic [7:0] sg;
    int         nd;
    nd = w ? 4 : 5;
    for (int i = 0; i < 5; i++) begin
      seen[i] = 1'b0;
      obs[i]  = 8'h00;
    end
    step();
    step();
    for (int c = 0; c < 48; c++) begin
      an = dut_an(w);
      sg = dut_seg(w);
      for (int i = 0; i < nd; i++) begin
        if (an == ~(5'b00001 << i)) begin
          if (!seen[i] || sg != exp[8*i +: 8]) obs[i] = sg;
          seen[i] = 1'b1;
        end
      end
      step();
    end
    for (int i = 0; i < nd; i++) begin
      if (seen[i]) check($sformatf("%s digit%0d", name, i), {32'h0, obs[i]}, {32'h0, exp[8*i +: 8]});
      else         check($sformatf("%s digit%0d never selected", name, i), 40'h1, 40'h0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          nb, bad, lows, multi, cur, run, idx;
    bit          full, wrapped;
    logic [19:0] lb, prev;
    logic [4:0]  an;
    logic [7:0]  pwm_set [3];

    vecs[0] = '{16'd0,     1'b1, 20'h00000, 40'hFF_FF_FF_FF_C0};
    vecs[1] = '{16'd1,     1'b0, 20'h00001, 40'hC0_C0_C0_C0_F9};
    vecs[2] = '{16'd42,    1'b1, 20'h00042, 40'hFF_FF_FF_99_A4};
    vecs[3] = '{16'd305,   1'b1, 20'h00305, 40'hFF_FF_B0_C0_92};
    vecs[4] = '{16'd305,   1'b0, 20'h00305, 40'hC0_C0_B0_C0_92};
    vecs[5] = '{16'd76,    1'b1, 20'h00076, 40'hFF_FF_FF_F8_82};
    vecs[6] = '{16'd8,     1'b1, 20'h00008, 40'hFF_FF_FF_FF_80};
    vecs[7] = '{16'd9999,  1'b1, 20'h09999, 40'hFF_90_90_90_90};
    vecs[8] = '{16'd10000, 1'b1, 20'h10000, 40'hF9_C0_C0_C0_C0};
    vecs[9] = '{16'd65535, 1'b0, 20'h65535, 40'h82_92_92_B0_92};

    bus5.value = '0; bus5.valid = 1'b0; bus5.blank_lz = 1'b0; bus5.pwm_in = 8'd255;
    bus4.value = '0; bus4.valid = 1'b0; bus4.blank_lz = 1'b1; bus4.pwm_in = 8'd255;

    // Asynchronous reset before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("reset busy",     {39'h0, bus5.busy},      40'h0);
    check("reset overflow", {39'h0, bus5.overflow},  40'h0);
    check("reset bcd_out",  {20'h0, bus5.bcd_out},   40'h0);
    check("reset anodes",   {35'h0, bus5.SegmentDrivers}, 40'h1F);
    check("reset segments", {32'h0, bus5.SevenSegment},   40'hFF);
    check("reset anodes dut4", {36'h0, bus4.SegmentDrivers}, 40'hF);
    step();
    step();
    rst_n = 1'b1;

    prev = 20'h0;
    for (int k = 0; k < 10; k++) begin
      bus5.blank_lz = vecs[k].blank;
      convert(1'b0, vecs[k].value, nb, lb);
      check($sformatf("v%0d busy cycles", k), 40'(nb), 40'd17);
      check($sformatf("v%0d bcd before commit", k), {20'h0, lb}, {20'h0, prev});
      check($sformatf("v%0d bcd", k), {20'h0, dut_bcd(1'b0)}, {20'h0, vecs[k].bcd});
      check($sformatf("v%0d overflow", k), {39'h0, dut_ovf(1'b0)}, 40'h0);
      check_digits($sformatf("v%0d", k), 1'b0, vecs[k].segs);
      prev = vecs[k].bcd;
    end

    // Four-digit instance: overflow keeps the low digits and shows dashes even with blanking.
    convert(1'b1, 16'd12345, nb, lb);
    check("ovf busy cycles", 40'(nb), 40'd17);
    check("ovf bcd", {20'h0, dut_bcd(1'b1)}, 40'h02345);
    check("ovf flag", {39'h0, dut_ovf(1'b1)}, 40'h1);
    check_digits("ovf", 1'b1, 40'h00_BF_BF_BF_BF);
    convert(1'b1, 16'd9999, nb, lb);
    check("max fit bcd", {20'h0, dut_bcd(1'b1)}, 40'h09999);
    check("max fit flag", {39'h0, dut_ovf(1'b1)}, 40'h0);
    check_digits("max fit", 1'b1, 40'h00_90_90_90_90);

    // Back-to-back: 7 is superseded by 42 while 100 converts.
    bus5.value = 16'd100; bus5.valid = 1'b1;
    step();
    check("b2b accepted", {39'h0, bus5.busy}, 40'h1);
    bus5.value = 16'd7;
    step();
    bus5.value = 16'd42;
    step();
    bus5.valid = 1'b0;
    repeat (14) step();
    check("b2b bcd before first commit", {20'h0, bus5.bcd_out}, 40'h65535);
    step();
    check("b2b first commit", {20'h0, bus5.bcd_out}, 40'h00100);
    check("b2b no idle gap", {39'h0, bus5.busy}, 40'h1);
    bad = 0;
    repeat (16) begin
      step();
      if (bus5.bcd_out != 20'h00100 || !bus5.busy) bad++;
    end
    check("b2b hold during second conversion", 40'(bad), 40'h0);
    step();
    check("b2b second commit", {20'h0, bus5.bcd_out}, 40'h00042);
    check("b2b idle after", {39'h0, bus5.busy}, 40'h0);

    // A load landing on the COMMIT edge chains straight into a new conversion.
    bus5.value = 16'd100; bus5.valid = 1'b1;
    step();
    bus5.valid = 1'b0;
    repeat (16) step();
    bus5.value = 16'd77; bus5.valid = 1'b1;
    step();
    bus5.valid = 1'b0;
    check("commit-edge load first result", {20'h0, bus5.bcd_out}, 40'h00100);
    check("commit-edge load busy", {39'h0, bus5.busy}, 40'h1);
    repeat (17) step();
    check("commit-edge load second result", {20'h0, bus5.bcd_out}, 40'h00077);
    check("commit-edge load idle", {39'h0, bus5.busy}, 40'h0);

    // PWM duty: anode-low samples per 256-cycle window.
    pwm_set[0] = 8'd0; pwm_set[1] = 8'd128; pwm_set[2] = 8'd255;
    for (int p = 0; p < 3; p++) begin
      bus5.pwm_in = pwm_set[p];
      repeat (3) step();
      lows = 0;
      multi = 0;
      repeat (256) begin
        an = bus5.SegmentDrivers;
        if (an != 5'h1F) lows++;
        if ($countones(~an) > 1) multi++;
        step();
      end
      check($sformatf("pwm %0d low cycles", pwm_set[p]), 40'(lows), {32'h0, pwm_set[p]});
      check($sformatf("pwm %0d single anode", pwm_set[p]), 40'(multi), 40'h0);
    end

    // Mux: index advances by one every 4 cycles and wraps 4 -> 0.
    bus5.pwm_in = 8'd255;
    cur = -1; run = 0; bad = 0; full = 1'b0; wrapped = 1'b0;
    repeat (80) begin
      an  = bus5.SegmentDrivers;
      idx = -1;
      for (int i = 0; i < 5; i++) if (an == ~(5'b00001 << i)) idx = i;
      if (idx >= 0 && idx != cur) begin
        if (cur >= 0) begin
          if (idx != (cur + 1) % 5) bad++;
          if (full && run != 4) bad++;
          if (cur == 4 && idx == 0) wrapped = 1'b1;
          full = 1'b1;
        end
        cur = idx;
        run = 1;
      end else begin
        run++;
      end
      step();
    end
    check("mux order and period", 40'(bad), 40'h0);
    check("mux wraps 4 to 0", {39'h0, wrapped}, 40'h1);

    // Reset in the middle of converting 999.
    bus5.value = 16'd999; bus5.valid = 1'b1;
    step();
    bus5.valid = 1'b0;
    repeat (7) step();
    rst_n = 1'b0;
    #1;
    check("mid reset busy",     {39'h0, bus5.busy},     40'h0);
    check("mid reset bcd",      {20'h0, bus5.bcd_out},  40'h0);
    check("mid reset overflow", {39'h0, bus5.overflow}, 40'h0);
    check("mid reset anodes",   {35'h0, bus5.SegmentDrivers}, 40'h1F);
    check("mid reset segments", {32'h0, bus5.SevenSegment},   40'hFF);
    check("mid reset dut4 bcd", {20'h0, dut_bcd(1'b1)},       40'h0);
    step();
    step();
    rst_n = 1'b1;
    bus5.value = 16'd5; bus5.valid = 1'b1;
    step();
    bus5.valid = 1'b0;
    check("first valid after reset accepted", {39'h0, bus5.busy}, 40'h1);
    repeat (16) step();
    check("aborted value not committed", {20'h0, bus5.bcd_out}, 40'h0);
    step();
    check("post-reset commit", {20'h0, bus5.bcd_out}, 40'h00005);
    check("post-reset idle", {39'h0, bus5.busy}, 40'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_display_ctrl.md
BCD_DISPLAY_CTRL -- requirements
Module: bcd_display_ctrl

Interface
REQ-001 Parameter WIDTH, default 16, bit width of the binary value to display.
REQ-002 Parameter DIGITS, default 4, number of seven-segment digits driven; legal range 1..8.
REQ-003 Parameter REFRESH_DIV, default 100000, clock cycles each digit is selected before the mux advances; minimum 1.
REQ-004 CLK100MHZ  input  1  system clock; all state is updated on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 value  input  WIDTH  unsigned binary value, sampled only when valid=1 is accepted.
REQ-007 valid  input  1  single-cycle load strobe, for example a search done or found pulse.
REQ-008 blank_lz  input  1  when 1, leading zeros are blanked.
REQ-009 pwm_in  input  8  brightness duty.
REQ-010 busy  output  1  conversion in progress.
REQ-011 overflow  output  1  the last committed value exceeds 10^DIGITS-1.
REQ-012 bcd_out  output  4*DIGITS  committed BCD digits; digit 0 is in bits [3:0].
REQ-013 SegmentDrivers  output  DIGITS  digit anodes, active-low; bit i selects digit i.
REQ-014 SevenSegment  output  8  cathodes, active-low, ordered {dp,g,f,e,d,c,b,a}.

Function
REQ-015 The converter SHALL use a sequential shift-add-3 (double-dabble) method with states IDLE, SHIFT and COMMIT.
  - IDLE -> SHIFT: on a clock edge where valid=1.
  - SHIFT: performs exactly WIDTH shift steps, one per cycle.
  - COMMIT: lasts one cycle, then returns to IDLE.
REQ-016 With valid accepted at edge t, bcd_out and overflow SHALL update at edge t+WIDTH+1.
  - busy=1 from edge t through edge t+WIDTH+1.
  - busy returns to 0 after edge t+WIDTH+1.
REQ-017 The internal BCD scratch register SHALL be sized to hold 2^WIDTH-1.
  - overflow=1 at commit if any scratch digit above DIGITS-1 is nonzero.
  - On overflow, bcd_out SHALL hold the low DIGITS digits.
REQ-018 A valid that arrives while busy=1 SHALL be held in a one-deep pending register; if several arrive, the newest value wins.
  - The pending value starts conversion on the cycle after COMMIT, so IDLE lasts zero cycles.
  - No valid is ever silently dropped, except one superseded by a newer value.
REQ-019 valid coinciding with the COMMIT cycle SHALL be treated as pending under REQ-018.
REQ-020 The display SHALL always show the committed bcd_out; it never shows mid-conversion scratch data.
REQ-021 Digit mux: a refresh counter counts 0..REFRESH_DIV-1.
  - At terminal count, the digit index advances by 1 and wraps from DIGITS-1 to 0.
  - Exactly one anode is low when enabled.
REQ-022 PWM: a free-running 8-bit counter gates the anodes.
  - Selected anode is driven low only while pwm_cnt < pwm_in.
  - pwm_in=0 gives all anodes high (dark); pwm_in=255 gives a 255/256 duty.
REQ-023 Segment codes (dp always 1, i.e. off):
  - Digits 0-9: 0xC0,0xF9,0xA4,0xB0,0x99,0x92,0x82,0xF8,0x80,0x90.
  - Blank: 0xFF.
  - Dash: 0xBF.
REQ-024 When overflow=1, every digit SHALL show dash, regardless of blank_lz.
REQ-025 When blank_lz=1, digits above the most-significant nonzero digit SHALL show blank; digit 0 is never blanked, so value 0 shows "0".
REQ-026 SegmentDrivers and SevenSegment SHALL be registered, with one cycle of latency from the mux index to the pins, and no glitch between digits.
  - While anodes are disabled by PWM, SevenSegment still reflects the selected digit.

Reset
REQ-027 reset=0 SHALL immediately, and asynchronously, force the following:
  - state=IDLE; busy=0; overflow=0; bcd_out=0; pending cleared.
  - refresh counter, digit index and pwm_cnt = 0.
  - SegmentDrivers all 1s; SevenSegment=0xFF.
REQ-028 Reset mid-conversion SHALL abort the conversion; the aborted value is never committed.
REQ-029 After reset deasserts, the first valid is accepted on the first rising edge at which it is high.

Verification (WIDTH=16, DIGITS=5, REFRESH_DIV=4 unless stated)
REQ-030 Conversion: valid with value=65535.
  - busy=1 for 17 cycles.
  - bcd_out=0x65535 at edge t+17; overflow=0.
REQ-031 Overflow (DIGITS=4): value=12345.
  - overflow=1; bcd_out=0x2345; all four digits show 0xBF.
REQ-032 Back-to-back: valid with 100, then valid with 7 and valid with 42 during busy.
  - Commit 0x00100, then 0x00042; value 7 is never committed; no idle gap between conversions.
REQ-033 Blanking: value=305 with blank_lz=1.
  - Digits 4..0 show FF, FF, B0, C0, 92.
  - With blank_lz=0, digits 4..3 show C0.
REQ-034 PWM and mux, pwm_in=0 / 128 / 255:
  - Anodes low 0 / 128 / 255 of every 256 cycles.
  - The anode index advances every 4 cycles and wraps 4 -> 0.
REQ-035 Reset mid-conversion: reset=0 at cycle 8 of converting 999.
  - Outputs return to reset values within the same cycle.
  - A subsequent valid with 5 commits bcd_out=0x00005.
